// File: rtl/filter_pkg.sv
// Shared definitions for the RGB neighbourhood filters: FSM states, 3x3 tap indices, pixel width.
package filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam int TAP_TL   = 0;
    localparam int TAP_TC   = 1;
    localparam int TAP_TR   = 2;
    localparam int TAP_ML   = 3;
    localparam int TAP_C    = 4;
    localparam int TAP_MR   = 5;
    localparam int TAP_BL   = 6;
    localparam int TAP_BC   = 7;
    localparam int TAP_BR   = 8;
    localparam int NUM_TAPS = 9;

    // A pixel bundle is {r, g, b}, red in the top slice.
    function automatic int pix_bits(input int width);
        return 3 * width;
    endfunction

endpackage

// File: rtl/rgb_line_buffer.sv
// One-line delay for packed RGB pixels: combinational read, write on en (read-before-write).
// Zero-cycle read latency; no backpressure, caller advances it once per pixel.
module rgb_line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3840,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [AW-1:0]        addr,
    input  logic [3*WIDTH-1:0]   wr_dat,
    output logic [3*WIDTH-1:0]   rd_dat
);

    logic [3*WIDTH-1:0] mem [DEPTH];

    // Reading the old entry while overwriting it gives exactly one line of delay.
    assign rd_dat = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/rgb_window_3x3.sv
// 3x3 replicate-border RGB window generator; window for centre c registers the cycle after pixel c+ROWS+1.
// No backpressure: one window per accepted pixel, then ROWS+1 self-timed flush windows at frame end.
module rgb_window_3x3 import filter_pkg::*; #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 3840,
    parameter int LINE_BITS = 14,
    parameter int ROWS      = 3840,
    parameter int COLS      = 2160
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       r_data_in,
    input  logic [WIDTH-1:0]       g_data_in,
    input  logic [WIDTH-1:0]       b_data_in,
    input  logic                   data_in_done,
    output logic [9*WIDTH-1:0]     r_win,
    output logic [9*WIDTH-1:0]     g_win,
    output logic [9*WIDTH-1:0]     b_win,
    output logic                   win_valid,
    output logic [LINE_BITS-1:0]   win_x,
    output logic [LINE_BITS-1:0]   win_y,
    output logic                   frame_done,
    output logic                   err_overrun
);

    localparam int PW     = pix_bits(WIDTH);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LINE_BITS-1:0] X_LAST = LINE_BITS'(ROWS - 1);
    localparam logic [LINE_BITS-1:0] Y_LAST = LINE_BITS'(COLS - 1);

    state_t               state;
    logic [LINE_BITS-1:0] in_x, in_y, cx, cy;
    logic [PW-1:0]        in_pix, lb1_rd, lb2_rd;
    // Columns indexed by row: [0] = line y-1, [1] = line y, [2] = line y+1.
    logic [2:0][PW-1:0]   col0, col1, col_new;
    logic [9*WIDTH-1:0]   r_nxt, g_nxt, b_nxt;
    logic                 advance, emit;

    assign in_pix  = {r_data_in, g_data_in, b_data_in};
    assign col_new = {in_pix, lb1_rd, lb2_rd};
    // Flush keeps the line buffers stepping; its feed data only lands in taps that get replicated away.
    assign advance = (state == ST_FLUSH) || data_in_done;
    assign emit    = (state == ST_FLUSH) || ((state == ST_RUN) && data_in_done);

    rgb_line_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(RAM_AW)) u_lb1 (
        .clk    (clk),
        .en     (advance),
        .addr   (in_x[RAM_AW-1:0]),
        .wr_dat (in_pix),
        .rd_dat (lb1_rd)
    );

    rgb_line_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(RAM_AW)) u_lb2 (
        .clk    (clk),
        .en     (advance),
        .addr   (in_x[RAM_AW-1:0]),
        .wr_dat (lb1_rd),
        .rd_dat (lb2_rd)
    );

    always_comb begin
        logic [1:0]    row_s;
        logic [1:0]    col_s;
        logic [PW-1:0] pix;
        row_s = '0;
        col_s = '0;
        pix   = '0;
        r_nxt = '0;
        g_nxt = '0;
        b_nxt = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            row_s = 2'(k / 3);
            col_s = 2'(k % 3);
            // Replicate border: out-of-frame neighbours fall back to the centre row/column.
            if (row_s == 2'd0 && cy == '0)     row_s = 2'd1;
            if (row_s == 2'd2 && cy == Y_LAST) row_s = 2'd1;
            if (col_s == 2'd0 && cx == '0)     col_s = 2'd1;
            if (col_s == 2'd2 && cx == X_LAST) col_s = 2'd1;
            case (col_s)
                2'd0:    pix = col0[row_s];
                2'd1:    pix = col1[row_s];
                default: pix = col_new[row_s];
            endcase
            r_nxt[k*WIDTH +: WIDTH] = pix[2*WIDTH +: WIDTH];
            g_nxt[k*WIDTH +: WIDTH] = pix[WIDTH +: WIDTH];
            b_nxt[k*WIDTH +: WIDTH] = pix[0 +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            in_x        <= '0;
            in_y        <= '0;
            cx          <= '0;
            cy          <= '0;
            col0        <= '0;
            col1        <= '0;
            r_win       <= '0;
            g_win       <= '0;
            b_win       <= '0;
            win_valid   <= 1'b0;
            win_x       <= '0;
            win_y       <= '0;
            frame_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (state == ST_FLUSH && data_in_done) begin
                err_overrun <= 1'b1;
            end
            if (advance) begin
                col0 <= col1;
                col1 <= col_new;
                if (in_x == X_LAST) begin
                    in_x <= '0;
                    in_y <= (in_y == Y_LAST) ? '0 : in_y + LINE_BITS'(1);
                end else begin
                    in_x <= in_x + LINE_BITS'(1);
                end
            end
            if (emit) begin
                win_valid <= 1'b1;
                r_win     <= r_nxt;
                g_win     <= g_nxt;
                b_win     <= b_nxt;
                win_x     <= cx;
                win_y     <= cy;
                if (cx == X_LAST) begin
                    cx <= '0;
                    cy <= (cy == Y_LAST) ? '0 : cy + LINE_BITS'(1);
                end else begin
                    cx <= cx + LINE_BITS'(1);
                end
            end
            case (state)
                ST_IDLE:  if (data_in_done) state <= ST_FILL;
                // Pixel (0,1) completes the ROWS+1 pixels needed before the first window.
                ST_FILL:  if (data_in_done && in_x == '0 && in_y == LINE_BITS'(1)) state <= ST_RUN;
                ST_RUN:   if (data_in_done && in_x == X_LAST && in_y == Y_LAST) state <= ST_FLUSH;
                default: begin
                    if (cx == X_LAST && cy == Y_LAST) begin
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                        in_x       <= '0;
                        in_y       <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_window_3x3.sv
// Scoreboard bench for rgb_window_3x3 on a 4x3 frame; clamped-neighbour reference model.
module tb_rgb_window_3x3;

    localparam int W    = 8;
    localparam int R    = 4;
    localparam int C    = 3;
    localparam int LB   = 4;
    localparam int NPIX = R * C;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [W-1:0]      r_data_in = '0;
    logic [W-1:0]      g_data_in = '0;
    logic [W-1:0]      b_data_in = '0;
    logic              data_in_done = 1'b0;
    logic [9*W-1:0]    r_win, g_win, b_win;
    logic              win_valid;
    logic [LB-1:0]     win_x, win_y;
    logic              frame_done, err_overrun;

    always #5 clk = ~clk;

    rgb_window_3x3 #(.WIDTH(W), .DEPTH(4), .LINE_BITS(LB), .ROWS(R), .COLS(C)) dut (
        .clk          (clk),
        .reset        (reset),
        .r_data_in    (r_data_in),
        .g_data_in    (g_data_in),
        .b_data_in    (b_data_in),
        .data_in_done (data_in_done),
        .r_win        (r_win),
        .g_win        (g_win),
        .b_win        (b_win),
        .win_valid    (win_valid),
        .win_x        (win_x),
        .win_y        (win_y),
        .frame_done   (frame_done),
        .err_overrun  (err_overrun)
    );

    typedef struct {
        logic [9*W-1:0] r;
        logic [9*W-1:0] g;
        logic [9*W-1:0] b;
        logic [LB-1:0]  x;
        logic [LB-1:0]  y;
        logic           fd;
    } exp_t;

    exp_t     q[$];
    exp_t     me;
    int       tests = 0;
    int       fails = 0;
    int       win_cnt = 0;
    int       fd_cnt = 0;
    bit       mon_en = 1'b0;
    bit       prev_din = 1'b0;
    bit       frame_inputs_done = 1'b0;
    logic [W-1:0] fr_r [NPIX];
    logic [W-1:0] fr_g [NPIX];
    logic [W-1:0] fr_b [NPIX];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Each neighbour is the frame pixel at the clamped coordinate.
    task automatic push_expected();
        exp_t e;
        for (int c = 0; c < NPIX; c++) begin
            int x, y, tx, ty;
            x = c % R;
            y = c / R;
            for (int k = 0; k < 9; k++) begin
                tx = x + (k % 3) - 1;
                ty = y + (k / 3) - 1;
                if (tx < 0 || tx > R - 1) tx = x;
                if (ty < 0 || ty > C - 1) ty = y;
                e.r[k*W +: W] = fr_r[ty*R + tx];
                e.g[k*W +: W] = fr_g[ty*R + tx];
                e.b[k*W +: W] = fr_b[ty*R + tx];
            end
            e.x  = LB'(x);
            e.y  = LB'(y);
            e.fd = (c == NPIX - 1);
            q.push_back(e);
        end
    endtask

    task automatic send_frame(input bit rnd, input int gap_mode, input bit poke, input int npx, input bit lat_chk);
        int gaps;
        for (int p = 0; p < NPIX; p++) begin
            if (rnd) begin
                fr_r[p] = W'($urandom);
                fr_g[p] = W'($urandom);
                fr_b[p] = W'($urandom);
            end else begin
                fr_r[p] = W'(p);
                fr_g[p] = W'(p + 16);
                fr_b[p] = W'(p + 32);
            end
        end
        push_expected();
        win_cnt = 0;
        fd_cnt = 0;
        frame_inputs_done = 1'b0;
        for (int i = 0; i < npx; i++) begin
            r_data_in = fr_r[i];
            g_data_in = fr_g[i];
            b_data_in = fr_b[i];
            data_in_done = 1'b1;
            @(posedge clk); #1;
            data_in_done = 1'b0;
            if (i == NPIX - 1) frame_inputs_done = 1'b1;
            if (lat_chk && i < 5) check("no_early_window", win_valid, 1'b0);
            if (lat_chk && i == 5) check("first_window_latency", win_valid, 1'b1);
            if (i < npx - 1) begin
                gaps = (gap_mode == 1) ? 2 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
                repeat (gaps) begin @(posedge clk); #1; end
            end
        end
        if (poke) begin
            r_data_in = 8'hAA;
            data_in_done = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            data_in_done = 1'b0;
        end
    endtask

    task automatic finish_frame();
        int cyc = 0;
        while (q.size() != 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_timeout", q.size(), 0);
        repeat (4) begin @(posedge clk); #1; end
        check("window_count", win_cnt, NPIX);
        check("frame_done_count", fd_cnt, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_win_valid"}, win_valid, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_err_overrun"}, err_overrun, 1'b0);
        check({tag, "_r_win"}, r_win, '0);
        check({tag, "_g_win"}, g_win, '0);
        check({tag, "_b_win"}, b_win, '0);
        check({tag, "_win_x"}, win_x, '0);
        check({tag, "_win_y"}, win_y, '0);
    endtask

    always @(posedge clk) prev_din = data_in_done;

    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            if (win_valid) begin
                if (!prev_din && !frame_inputs_done) begin
                    fails++;
                    $display("FAIL gap_window: window at x=%0d y=%0d on an idle input cycle, required none", win_x, win_y);
                end else if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_window: got x=%0d y=%0d, required no window", win_x, win_y);
                end else begin
                    me = q.pop_front();
                    win_cnt++;
                    if (frame_done) fd_cnt++;
                    if ({r_win, g_win, b_win, win_x, win_y, frame_done} !== {me.r, me.g, me.b, me.x, me.y, me.fd}) begin
                        fails++;
                        $display("FAIL window(%0d,%0d): got r=%h g=%h b=%h x=%0d y=%0d fd=%b, required r=%h g=%h b=%h x=%0d y=%0d fd=%b",
                                 me.x, me.y, r_win, g_win, b_win, win_x, win_y, frame_done,
                                 me.r, me.g, me.b, me.x, me.y, me.fd);
                    end
                end
            end else if (frame_done !== 1'b0) begin
                fails++;
                $display("FAIL frame_done_without_window: got 1, required 0");
            end
        end
    end

    initial begin
        #2 reset = 1'b0;
        #20;
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        mon_en = 1'b1;

        send_frame(1'b0, 0, 1'b0, NPIX, 1'b1);
        finish_frame();
        check("no_overrun_a", err_overrun, 1'b0);

        send_frame(1'b0, 1, 1'b0, NPIX, 1'b0);
        finish_frame();
        check("no_overrun_b", err_overrun, 1'b0);

        send_frame(1'b0, 0, 1'b1, NPIX, 1'b0);
        finish_frame();
        check("overrun_set", err_overrun, 1'b1);

        send_frame(1'b1, 2, 1'b0, NPIX, 1'b0);
        finish_frame();
        check("overrun_sticky", err_overrun, 1'b1);

        send_frame(1'b0, 0, 1'b0, 7, 1'b0);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        q.delete();
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;

        send_frame(1'b0, 0, 1'b0, NPIX, 1'b1);
        finish_frame();
        check("no_overrun_after_reset", err_overrun, 1'b0);

        repeat (2) begin
            send_frame(1'b1, 2, 1'b0, NPIX, 1'b0);
            finish_frame();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
